// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS31 checker: FSM state encoding, register length,
// feedback taps and the next-bit predictor.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 27;
  localparam int TAP_B    = 30;

  // x^31 + x^28 + 1, with sr[0] holding the newest bit
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A] ^ sr[TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment loads 1 so the concurrent event is not lost.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,     // active-high asynchronous reset
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  // Next count: clear has priority, increment stops at all-ones
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      if (inc) begin
        cnt_nxt_s = W'(1);
      end else begin
        cnt_nxt_s = '0;
      end
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_nxt_s = cnt_r + W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 serial checker: fills a reference register, hunts for a run of
// matches, then free-runs its own generator and counts bit errors.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = 32,
  parameter int WIN_LEN     = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,     // active-high asynchronous reset
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int FW = $clog2(PRBS_LEN);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  state_e              state_r, state_nxt_s;
  logic [PRBS_LEN-1:0] sr_r, sr_nxt_s;
  logic [FW-1:0]       fill_r, fill_nxt_s;
  logic [MW-1:0]       match_r, match_nxt_s;
  logic [BW-1:0]       win_bit_r, win_bit_nxt_s;
  logic [EW-1:0]       win_err_r, win_err_nxt_s;
  logic                err_r, locked_r;
  logic                p_s, err_det_s;

  assign p_s = prbs_predict(sr_r);

  // Next-state, shift register and counter update; idle when no valid bit
  always_comb begin
    state_nxt_s   = state_r;
    sr_nxt_s      = sr_r;
    fill_nxt_s    = fill_r;
    match_nxt_s   = match_r;
    win_bit_nxt_s = win_bit_r;
    win_err_nxt_s = win_err_r;
    err_det_s     = 1'b0;
    if (din_valid) begin
      case (state_r)
        ST_SEED: begin
          sr_nxt_s = {sr_r[PRBS_LEN-2:0], din};
          if (fill_r == FW'(PRBS_LEN - 1)) begin
            fill_nxt_s  = '0;
            match_nxt_s = '0;
            state_nxt_s = ST_HUNT;
          end else begin
            fill_nxt_s = fill_r + FW'(1);
          end
        end
        ST_HUNT: begin
          sr_nxt_s = {sr_r[PRBS_LEN-2:0], din};
          // an all-zero register predicts zeros forever, so it never counts as a match
          if ((din == p_s) && (sr_r != '0)) begin
            if (match_r == MW'(LOCK_THRESH - 1)) begin
              match_nxt_s   = '0;
              win_bit_nxt_s = '0;
              win_err_nxt_s = '0;
              state_nxt_s   = ST_LOCKED;
            end else begin
              match_nxt_s = match_r + MW'(1);
            end
          end else begin
            match_nxt_s = '0;
          end
        end
        ST_LOCKED: begin
          sr_nxt_s  = {sr_r[PRBS_LEN-2:0], p_s};
          err_det_s = (din != p_s);
          if (err_det_s && (win_err_r == EW'(UNLOCK_ERRS - 1))) begin
            win_bit_nxt_s = '0;
            win_err_nxt_s = '0;
            fill_nxt_s    = '0;
            state_nxt_s   = ST_SEED;
          end else if (win_bit_r == BW'(WIN_LEN - 1)) begin
            win_bit_nxt_s = '0;
            win_err_nxt_s = '0;
          end else begin
            win_bit_nxt_s = win_bit_r + BW'(1);
            if (err_det_s) begin
              win_err_nxt_s = win_err_r + EW'(1);
            end else begin
              win_err_nxt_s = win_err_r;
            end
          end
        end
        default: begin
          state_nxt_s = ST_SEED;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r   <= ST_SEED;
      sr_r      <= '0;
      fill_r    <= '0;
      match_r   <= '0;
      win_bit_r <= '0;
      win_err_r <= '0;
      err_r     <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      sr_r      <= sr_nxt_s;
      fill_r    <= fill_nxt_s;
      match_r   <= match_nxt_s;
      win_bit_r <= win_bit_nxt_s;
      win_err_r <= win_err_nxt_s;
      err_r     <= err_det_s;
      locked_r  <= (state_nxt_s == ST_LOCKED);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_cnt),
    .inc   (err_det_s),
    .count (err_count)
  );

  assign locked = locked_r;
  assign err    = err_r;
  assign state  = state_r;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: default instance plus a 4-bit error
// counter instance sharing the same stimulus.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n, din, din_valid, clear_cnt;
  logic        locked, err, locked4, err4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  state, state4;
  logic [30:0] gen_sr;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err(err), .err_count(err_count), .state(state)
  );

  prbs31_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked4), .err(err4), .err_count(err_count4), .state(state4)
  );

  task automatic next_bit(output logic b);
    b = gen_sr[27] ^ gen_sr[30];
    gen_sr = {gen_sr[29:0], b};
  endtask

  task automatic step(input logic b, input logic v);
    din = b;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    gen_sr = 31'd1;
  endtask

  task automatic lock_up();
    logic b;
    for (int i = 1; i <= 63; i++) begin
      next_bit(b);
      step(b, 1'b1);
    end
    n_vec++;
    if (locked !== 1'b1 || locked4 !== 1'b1) begin
      n_err++;
      $display("FAIL lock_up: locked=%b locked4=%b, required 1/1", locked, locked4);
    end
  endtask

  task automatic test_reset();
    din = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0; rst_n = 1'b1;
    #3;
    n_vec++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || state !== 2'd0 || err_count4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: locked=%b err=%b cnt=%0d state=%0d, required 0/0/0/0", locked, err, err_count, state);
    end
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    n_vec++;
    if (state !== 2'd0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: state=%0d locked=%b, required 0/0", state, locked);
    end
  endtask

  task automatic test_lock();
    logic b;
    int   errs = 0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      next_bit(b);
      if (i % 5 == 0) step(~b, 1'b0);
      step(b, 1'b1);
      if (err === 1'b1) errs++;
      n_vec++;
      if (locked !== (i >= 63)) begin
        n_err++;
        $display("FAIL lock_timing: bit %0d locked=%b, required %b", i, locked, (i >= 63));
      end
    end
    n_vec++;
    if (errs != 0 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL lock_clean: err pulses=%0d err_count=%0d, required 0/0", errs, err_count);
    end
  endtask

  task automatic test_single_error();
    logic b;
    int   pulses;
    next_bit(b);
    step(~b, 1'b1);
    n_vec++;
    if (err !== 1'b1 || err_count !== 16'd1) begin
      n_err++;
      $display("FAIL single_err_pulse: err=%b err_count=%0d, required 1/1", err, err_count);
    end
    pulses = 1;
    for (int i = 0; i < 100; i++) begin
      next_bit(b);
      step(b, 1'b1);
      if (err === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL single_err_after: pulses=%0d err_count=%0d locked=%b, required 1/1/1", pulses, err_count, locked);
    end
  endtask

  task automatic test_zero_stream();
    logic seen = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1);
      if (state === 2'd2 || locked !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || state !== 2'd1) begin
      n_err++;
      $display("FAIL zero_stream: reached_lock=%b state=%0d, required 0/1", seen, state);
    end
  endtask

  task automatic test_unlock();
    logic b;
    do_reset();
    lock_up();
    for (int k = 0; k <= 35; k++) begin
      next_bit(b);
      step((k % 5 == 0) ? ~b : b, 1'b1);
      n_vec++;
      if (locked !== (k < 35)) begin
        n_err++;
        $display("FAIL unlock_timing: k=%0d locked=%b, required %b", k, locked, (k < 35));
      end
    end
    n_vec++;
    if (state !== 2'd0 || err_count !== 16'd8 || err !== 1'b1) begin
      n_err++;
      $display("FAIL unlock_state: state=%0d err_count=%0d err=%b, required 0/8/1", state, err_count, err);
    end
    for (int j = 1; j <= 63; j++) begin
      next_bit(b);
      step(b, 1'b1);
      n_vec++;
      if (locked !== (j >= 63)) begin
        n_err++;
        $display("FAIL relock_timing: bit %0d locked=%b, required %b", j, locked, (j >= 63));
      end
    end
    n_vec++;
    if (err_count !== 16'd8) begin
      n_err++;
      $display("FAIL relock_count: err_count=%0d, required 8", err_count);
    end
  endtask

  task automatic test_saturate();
    logic b;
    do_reset();
    lock_up();
    for (int e = 0; e < 20; e++) begin
      next_bit(b);
      step(~b, 1'b1);
      for (int i = 0; i < 15; i++) begin
        next_bit(b);
        step(b, 1'b1);
      end
    end
    n_vec++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked4 !== 1'b1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: cnt4=%0d cnt16=%0d locked4=%b, required 15/20/1", err_count4, err_count, locked4);
    end
    clear_cnt = 1'b1;
    next_bit(b);
    step(~b, 1'b1);
    clear_cnt = 1'b0;
    n_vec++;
    if (err_count4 !== 4'd1 || err_count !== 16'd1) begin
      n_err++;
      $display("FAIL clear_with_err: cnt4=%0d cnt16=%0d, required 1/1", err_count4, err_count);
    end
    clear_cnt = 1'b1;
    next_bit(b);
    step(b, 1'b1);
    clear_cnt = 1'b0;
    n_vec++;
    if (err_count4 !== 4'd0 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL clear_only: cnt4=%0d cnt16=%0d, required 0/0", err_count4, err_count);
    end
  endtask

  task automatic test_reset_midop();
    logic b;
    int   pulses = 0;
    next_bit(b);
    step(~b, 1'b1);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || state !== 2'd0 ||
        locked4 !== 1'b0 || err4 !== 1'b0 || err_count4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_midop: locked=%b err=%b cnt=%0d state=%0d, required 0/0/0/0", locked, err, err_count, state);
    end
    for (int i = 0; i < 4; i++) begin
      din_valid = i[0];
      din = ~din;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    gen_sr = 31'd1;
    for (int i = 0; i < 5; i++) begin
      next_bit(b);
      step(b, 1'b1);
      if (err === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0 || state !== 2'd0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: pulses=%0d state=%0d locked=%b, required 0/0/0", pulses, state, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_zero_stream();
    test_unlock();
    test_saturate();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 32, is the number of consecutive matched bits in HUNT required to declare lock.
REQ-002 Parameter WIN_LEN, default 64, is the length of the error-monitoring window in LOCKED, counted in valid bits.
REQ-003 Parameter UNLOCK_ERRS, default 8, is the number of errors within one window that forces loss of lock.
REQ-004 Parameter CNT_W, default 16, is the width of the error counter.
REQ-005 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  is the reset: asynchronous, active-high (asserted = 1, despite the name).
REQ-007 din  input  1  is the serial PRBS31 bit under test, sampled only when din_valid=1.
REQ-008 din_valid  input  1  is the per-cycle bit qualifier; when 0, no state, counter or shift register changes.
REQ-009 clear_cnt  input  1  is a synchronous clear of err_count.
REQ-010 locked  output  1  is high while the FSM is in LOCKED.
REQ-011 err  output  1  is a one-cycle error pulse, registered.
REQ-012 err_count  output  CNT_W  is the saturating count of errors detected in LOCKED.
REQ-013 state  output  2  is the FSM state (SEED=0, HUNT=1, LOCKED=2).

Function
REQ-014 The checker SHALL hold a 31-bit shift register sr, with sr[0] the newest bit; the predicted bit is p = sr[27] XOR sr[30] (polynomial x^31+x^28+1).
REQ-015 In SEED the checker SHALL shift din into sr on every valid bit, and after 31 valid bits it SHALL move to HUNT with a zeroed match counter.
REQ-016 In HUNT, on each valid bit, the checker SHALL compare din against p and shift din into sr.
REQ-017 In HUNT, a match with sr non-zero SHALL increment the match counter, and a mismatch or an all-zero sr SHALL clear it.
REQ-018 When the match counter reaches LOCK_THRESH, the checker SHALL enter LOCKED, so locked rises on the cycle after the LOCK_THRESH-th match.
REQ-019 In LOCKED the checker SHALL shift p (not din) into sr, so each corrupted input bit yields exactly one error.
REQ-020 In LOCKED, a valid bit with din != p SHALL pulse err high for exactly the next cycle and increment err_count.
REQ-021 err_count SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-022 clear_cnt SHALL zero err_count; when clear_cnt coincides with an error, err_count SHALL become 1.
REQ-023 In LOCKED the checker SHALL keep a window bit counter and a window error counter; both SHALL reset to 0 after WIN_LEN valid bits.
REQ-024 When the window error counter reaches UNLOCK_ERRS, the checker SHALL go to SEED on that cycle's edge, clear the window counters and the fill counter, and retain err_count.
REQ-025 In HUNT or SEED, err SHALL stay 0 and err_count SHALL remain frozen.
REQ-026 An all-zero input stream SHALL never produce lock.

Reset
REQ-027 Reset SHALL force, asynchronously: sr=0, state=SEED, all internal counters=0, locked=0, err=0, err_count=0.
REQ-028 Reset asserted mid-operation (any state) SHALL abort immediately, with no err pulse on release.

Structure
REQ-029 A shared package prbs_pkg SHALL hold the state encoding, PRBS31 length (31), and tap indices (27, 30).
REQ-030 The saturating error counter with clear SHALL be a sub-module, sat_counter (parameter W), instanced once; everything else is inline.

Verification
REQ-031 Reset, then feed 200 valid bits of the PRBS31 stream from seed 1 -> locked=1 on the cycle after valid bit 63 (31 fill + 32 matches), err_count=0 throughout.
REQ-032 After lock, invert a single bit -> exactly one err pulse and err_count=1, with no further errors over 100 following bits.
REQ-033 Feed 300 valid zero bits -> state never reaches LOCKED and locked stays 0.
REQ-034 After lock, corrupt 8 bits within 40 bits -> locked falls after the 8th error, state=SEED, err_count=8; the clean stream then relocks 63 valid bits later.
REQ-035 With CNT_W=4, inject 20 spaced errors -> err_count holds at 15; then assert clear_cnt together with an error -> err_count=1.
REQ-036 Assert rst_n while LOCKED with din_valid toggling -> locked, err and err_count are 0 immediately; state=SEED.
